// File: rtl/gtxe2_chnl_tx_oob_seq.sv
// SATA OOB burst sequencer: emits COMINIT/COMRESET or COMWAKE as ALIGNp bursts
// separated by electrical-idle gaps, tracking running disparity across words.
module gtxe2_chnl_tx_oob_seq #(
  parameter int WIDTH        = 20,
  parameter int BURST_SYM    = 16,
  parameter int INIT_GAP_SYM = 48,
  parameter int WAKE_GAP_SYM = 16,
  parameter int BURST_CNT    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             TXCOMINIT,
  input  logic             TXCOMWAKE,
  input  logic             abort,
  input  logic             disparity_in,
  output logic [WIDTH-1:0] outdata,
  output logic             outval,
  output logic             outidle,
  output logic             disparity_out,
  output logic             busy,
  output logic             TXCOMFINISH
);

  localparam int SYMS           = WIDTH / 10;
  localparam int BURST_WORDS    = BURST_SYM / SYMS;
  localparam int INIT_GAP_WORDS = INIT_GAP_SYM / SYMS;
  localparam int WAKE_GAP_WORDS = WAKE_GAP_SYM / SYMS;
  localparam int GAP_MAX        = (INIT_GAP_WORDS > WAKE_GAP_WORDS) ? INIT_GAP_WORDS : WAKE_GAP_WORDS;
  localparam int MAX_WORDS      = (BURST_WORDS > GAP_MAX) ? BURST_WORDS : GAP_MAX;
  localparam int CW             = $clog2(MAX_WORDS + 1);

  localparam logic [CW-1:0] BURST_LAST     = CW'(BURST_WORDS);
  localparam logic [CW-1:0] INIT_GAP_LAST  = CW'(INIT_GAP_WORDS);
  localparam logic [CW-1:0] WAKE_GAP_LAST  = CW'(WAKE_GAP_WORDS);
  localparam logic [3:0]    BURST_CNT_LAST = 4'(BURST_CNT);

  localparam logic [9:0] K28_5_NEG = 10'b0011111010;
  localparam logic [9:0] K28_5_POS = 10'b1100000101;
  localparam logic [9:0] D10_2     = 10'b0101010101;
  localparam logic [9:0] D27_3_NEG = 10'b1101100011;
  localparam logic [9:0] D27_3_POS = 10'b0010011100;

  typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    word_cnt, word_cnt_next;
  logic [3:0]       burst_cnt, burst_cnt_next, burst_cnt_inc;
  logic [1:0]       sym_idx, sym_idx_next;
  logic             disp, disp_next;
  logic             mode_init, mode_init_next;
  logic             init_prev, wake_prev, armed;
  logic             init_edge, wake_edge;
  logic [CW-1:0]    gap_last;
  logic             emit, restart, seq_start;
  logic [1:0]       g_idx;
  logic             g_rd;
  logic [WIDTH-1:0] gen_word;
  logic [WIDTH-1:0] outdata_next;
  logic             outval_next, outidle_next, busy_next, finish_next;

  // Reset asserts immediately but is released only on a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_core;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_pipe <= 2'b11;
    else       rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst_core = rst_pipe[1];

  function automatic logic [9:0] align_sym(input logic [1:0] idx, input logic rd);
    case (idx)
      2'd0:    align_sym = rd ? K28_5_POS : K28_5_NEG;
      2'd3:    align_sym = rd ? D27_3_POS : D27_3_NEG;
      default: align_sym = D10_2;
    endcase
  endfunction

  // The first clock after reset only samples the request levels, so a level
  // that was already high at release is not mistaken for an edge.
  assign init_edge     = armed & TXCOMINIT & ~init_prev;
  assign wake_edge     = armed & TXCOMWAKE & ~wake_prev;
  assign gap_last      = mode_init ? INIT_GAP_LAST : WAKE_GAP_LAST;
  assign burst_cnt_inc = burst_cnt + 4'd1;

  always_comb begin
    state_next     = state;
    word_cnt_next  = word_cnt;
    burst_cnt_next = burst_cnt;
    mode_init_next = mode_init;
    emit           = 1'b0;
    restart        = 1'b0;
    seq_start      = 1'b0;

    case (state)
      IDLE: begin
        if ((init_edge || wake_edge) && !abort) begin
          state_next     = BURST;
          mode_init_next = init_edge;
          burst_cnt_next = 4'd0;
          word_cnt_next  = CW'(1);
          emit           = 1'b1;
          restart        = 1'b1;
          seq_start      = 1'b1;
        end
      end
      BURST: begin
        if (abort) begin
          state_next = IDLE;
        end else if (word_cnt == BURST_LAST) begin
          state_next    = GAP;
          word_cnt_next = CW'(1);
        end else begin
          word_cnt_next = word_cnt + CW'(1);
          emit          = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_next = IDLE;
        end else if (word_cnt == gap_last) begin
          burst_cnt_next = burst_cnt_inc;
          if (burst_cnt_inc == BURST_CNT_LAST) begin
            state_next = DONE;
          end else begin
            state_next    = BURST;
            word_cnt_next = CW'(1);
            emit          = 1'b1;
            restart       = 1'b1;
          end
        end else begin
          word_cnt_next = word_cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Build one output word symbol by symbol, carrying ALIGNp position and
  // running disparity from slot 0 upward.
  always_comb begin
    g_idx    = restart ? 2'd0 : sym_idx;
    g_rd     = seq_start ? disparity_in : disp;
    gen_word = '0;
    for (int k = 0; k < SYMS; k++) begin
      gen_word[10*k +: 10] = align_sym(g_idx, g_rd);
      if (g_idx == 2'd0 || g_idx == 2'd3) g_rd = ~g_rd;
      g_idx = g_idx + 2'd1;
    end
  end

  always_comb begin
    outdata_next = emit ? gen_word : '0;
    sym_idx_next = emit ? g_idx : sym_idx;
    disp_next    = emit ? g_rd : disp;
    outval_next  = emit;
    outidle_next = (state_next == GAP);
    busy_next    = (state_next == BURST) || (state_next == GAP);
    finish_next  = (state_next == DONE);
  end

  always_ff @(posedge clk or posedge rst_core) begin
    if (rst_core) begin
      state       <= IDLE;
      word_cnt    <= '0;
      burst_cnt   <= '0;
      sym_idx     <= '0;
      disp        <= 1'b0;
      mode_init   <= 1'b0;
      init_prev   <= 1'b0;
      wake_prev   <= 1'b0;
      armed       <= 1'b0;
      outdata     <= '0;
      outval      <= 1'b0;
      outidle     <= 1'b0;
      busy        <= 1'b0;
      TXCOMFINISH <= 1'b0;
    end else begin
      state       <= state_next;
      word_cnt    <= word_cnt_next;
      burst_cnt   <= burst_cnt_next;
      sym_idx     <= sym_idx_next;
      disp        <= disp_next;
      mode_init   <= mode_init_next;
      init_prev   <= TXCOMINIT;
      wake_prev   <= TXCOMWAKE;
      armed       <= 1'b1;
      outdata     <= outdata_next;
      outval      <= outval_next;
      outidle     <= outidle_next;
      busy        <= busy_next;
      TXCOMFINISH <= finish_next;
    end
  end

  assign disparity_out = rst_core ? 1'b0 : ((state == IDLE) ? disparity_in : disp);

endmodule
